// File: rtl/mil_ring_buffer_n_pkg.sv
// Shared types and helpers for the N-ring FIFO controller.
package mil_ring_buffer_n_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    READ_WAIT,
    POP_DONE
  } rb_state_e;

  // Read-latency down-counter width; MEM_RD_LAT is limited to 1..4.
  localparam int unsigned LAT_W = 2;

  function automatic logic [31:0] ring_base(input logic [31:0] base_addr,
                                            input int unsigned idx,
                                            input int unsigned ring_log2);
    return base_addr + (32'(idx) << ring_log2);
  endfunction

endpackage

// File: rtl/mil_ring_buffer_n_rr_arbiter.sv
// Round-robin arbiter: search starts at the ring after the last grant.
module mil_ring_buffer_n_rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 en,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx
);
  localparam int unsigned IW = $clog2(N);

  logic [IW-1:0] ptr;
  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    grant = '0;
    idx   = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IW'((32'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (en && found)
      ptr <= (32'(idx) == N - 1) ? '0 : idx + IW'(1);
  end

endmodule

// File: rtl/mil_ring_buffer_n.sv
// N independent word FIFOs multiplexed onto one single-port memory bus,
// with per-ring status, flush and error reporting.
module mil_ring_buffer_n
  import mil_ring_buffer_n_pkg::*;
#(
  parameter int unsigned       NUM_RINGS  = 4,
  parameter int unsigned       DATA_W     = 16,
  parameter int unsigned       ADDR_W     = 16,
  parameter int unsigned       RING_LOG2  = 6,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int unsigned       MEM_RD_LAT = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_RINGS-1:0]               push_req,
  input  logic [NUM_RINGS*DATA_W-1:0]        push_data,
  output logic [NUM_RINGS-1:0]               push_done,
  output logic [NUM_RINGS-1:0]               push_err,
  input  logic [NUM_RINGS-1:0]               pop_req,
  output logic [DATA_W-1:0]                  pop_data,
  output logic [NUM_RINGS-1:0]               pop_done,
  output logic [NUM_RINGS-1:0]               pop_err,
  input  logic [NUM_RINGS-1:0]               flush,
  output logic [NUM_RINGS*(RING_LOG2+1)-1:0] count,
  output logic [NUM_RINGS-1:0]               full,
  output logic [NUM_RINGS-1:0]               empty,
  output logic [ADDR_W-1:0]                  mem_addr,
  output logic [DATA_W-1:0]                  mem_wdata,
  output logic                               mem_wr,
  output logic                               mem_rd,
  input  logic [DATA_W-1:0]                  mem_rdata
);
  localparam int unsigned PW    = RING_LOG2;
  localparam int unsigned CW    = RING_LOG2 + 1;
  localparam int unsigned RIW   = $clog2(NUM_RINGS);
  localparam int unsigned DEPTH = 1 << RING_LOG2;

  rb_state_e      state;
  logic [RIW-1:0] cur;
  logic           op_flushed;
  logic [LAT_W-1:0] lat_cnt;

  logic [PW-1:0] wr_ptr   [NUM_RINGS];
  logic [PW-1:0] rd_ptr   [NUM_RINGS];
  logic [CW-1:0] cnt      [NUM_RINGS];
  logic [PW-1:0] wr_ptr_n [NUM_RINGS];
  logic [PW-1:0] rd_ptr_n [NUM_RINGS];
  logic [CW-1:0] cnt_n    [NUM_RINGS];

  logic [NUM_RINGS-1:0] arb_grant;
  logic [RIW-1:0]       arb_idx;
  logic                 commit;

  function automatic logic [ADDR_W-1:0] slot_addr(input logic [RIW-1:0] r,
                                                  input logic [PW-1:0]  p);
    return ADDR_W'(ring_base(32'(BASE_ADDR), 32'(r), RING_LOG2) + 32'(p));
  endfunction

  mil_ring_buffer_n_rr_arbiter #(.N(NUM_RINGS)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (push_req | pop_req),
    .en    (state == IDLE),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  // An op whose ring was flushed while in flight still completes on the bus
  // but must not move the (already cleared) pointers.
  assign commit = !op_flushed && (state == WRITE || state == POP_DONE);

  always_comb begin
    for (int unsigned i = 0; i < NUM_RINGS; i++) begin
      wr_ptr_n[i] = wr_ptr[i];
      rd_ptr_n[i] = rd_ptr[i];
      cnt_n[i]    = cnt[i];
      if (flush[i]) begin
        wr_ptr_n[i] = '0;
        rd_ptr_n[i] = '0;
        cnt_n[i]    = '0;
      end else if (commit && cur == RIW'(i)) begin
        if (state == WRITE) begin
          wr_ptr_n[i] = wr_ptr[i] + PW'(1);
          cnt_n[i]    = cnt[i] + CW'(1);
        end else begin
          rd_ptr_n[i] = rd_ptr[i] + PW'(1);
          cnt_n[i]    = cnt[i] - CW'(1);
        end
      end
    end
  end

  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < NUM_RINGS; i++)
      count[i*CW +: CW] = cnt[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_RINGS; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
      full  <= '0;
      empty <= '1;
    end else begin
      for (int unsigned i = 0; i < NUM_RINGS; i++) begin
        wr_ptr[i] <= wr_ptr_n[i];
        rd_ptr[i] <= rd_ptr_n[i];
        cnt[i]    <= cnt_n[i];
        full[i]   <= (cnt_n[i] == CW'(DEPTH));
        empty[i]  <= (cnt_n[i] == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cur        <= '0;
      op_flushed <= 1'b0;
      lat_cnt    <= '0;
      push_done  <= '0;
      push_err   <= '0;
      pop_done   <= '0;
      pop_err    <= '0;
      pop_data   <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wr     <= 1'b0;
      mem_rd     <= 1'b0;
    end else begin
      push_done  <= '0;
      push_err   <= '0;
      pop_done   <= '0;
      pop_err    <= '0;
      mem_wr     <= 1'b0;
      mem_rd     <= 1'b0;
      op_flushed <= op_flushed | flush[cur];
      unique case (state)
        IDLE: begin
          op_flushed <= 1'b0;
          if (|arb_grant) begin
            cur        <= arb_idx;
            op_flushed <= flush[arb_idx];
            if (push_req[arb_idx]) begin
              if (full[arb_idx]) begin
                push_err[arb_idx] <= 1'b1;
              end else begin
                state              <= WRITE;
                mem_wr             <= 1'b1;
                mem_addr           <= slot_addr(arb_idx, wr_ptr[arb_idx]);
                mem_wdata          <= push_data[arb_idx*DATA_W +: DATA_W];
                push_done[arb_idx] <= 1'b1;
              end
            end else if (empty[arb_idx]) begin
              pop_err[arb_idx] <= 1'b1;
            end else begin
              state    <= READ;
              mem_rd   <= 1'b1;
              mem_addr <= slot_addr(arb_idx, rd_ptr[arb_idx]);
            end
          end
        end
        WRITE: state <= IDLE;
        READ: begin
          state   <= READ_WAIT;
          lat_cnt <= LAT_W'(MEM_RD_LAT - 1);
        end
        READ_WAIT: begin
          if (lat_cnt == '0) begin
            state         <= POP_DONE;
            pop_data      <= mem_rdata;
            pop_done[cur] <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        POP_DONE: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mil_ring_buffer_n.md
Name: mil_ring_buffer_n

Overview:
Parametrised N-ring FIFO controller that maps NUM_RINGS independent word FIFOs onto one shared single-port memory bus. It generalises the fixed four-ring memory block of the MIL/SPI bridge, which used explicit per-ring START/END parameters. Ring count and ring size are parameters. Adds per-ring occupancy/full/empty status, per-ring flush, overflow and underflow error pulses, and round-robin arbitration. It sits between the SPI/MIL protocol engines (the requestors) and the memory wrapper.

Parameters:
NUM_RINGS, 4, number of rings/channels (2..16)
DATA_W, 16, word width
ADDR_W, 16, memory address width
RING_LOG2, 6, log2 ring depth in words (64 words per ring)
BASE_ADDR, 16'h0000, address of ring 0; ring i starts at BASE_ADDR + i*2^RING_LOG2
MEM_RD_LAT, 1, memory read latency in cycles (1..4)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
push_req  in  NUM_RINGS  per-ring write request; level, held until push_done or push_err
push_data  in  NUM_RINGS*DATA_W  write word; ring i uses slice [i*DATA_W +: DATA_W]
push_done  out  NUM_RINGS  1-cycle pulse: word written
push_err  out  NUM_RINGS  1-cycle pulse: push rejected because ring full
pop_req  in  NUM_RINGS  per-ring read request; level
pop_data  out  DATA_W  read word; valid while pop_done is high
pop_done  out  NUM_RINGS  1-cycle pulse: pop_data valid for that ring
pop_err  out  NUM_RINGS  1-cycle pulse: pop rejected because ring empty
flush  in  NUM_RINGS  clear ring pointers and count
count  out  NUM_RINGS*(RING_LOG2+1)  per-ring occupancy
full  out  NUM_RINGS  count == 2^RING_LOG2
empty  out  NUM_RINGS  count == 0
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_wr  out  1  memory write strobe, one cycle
mem_rd  out  1  memory read strobe, one cycle
mem_rdata  in  DATA_W  memory read data, valid MEM_RD_LAT cycles after mem_rd

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset: all outputs 0 except empty, which is all ones. All pointers and counts are 0. FSM goes to IDLE; arbiter pointer is 0.
- Reset mid-operation: any in-flight operation is abandoned; no done or err pulse is issued.
- FSM states: IDLE, WRITE, READ, READ_WAIT, POP_DONE.
- IDLE: requests are sampled only in this state. A ring is a candidate if push_req or pop_req is set. Round-robin selection starts at (last granted ring + 1) mod NUM_RINGS.
  - Within the selected ring, push beats pop.
  - Push to a full ring: push_err pulses next cycle; stay in IDLE; no memory access.
  - Pop from an empty ring: pop_err pulses next cycle; stay in IDLE; no memory access.
  - No candidate: stay in IDLE.
- Push latency: request seen in IDLE at cycle t. WRITE at t+1: mem_wr=1, mem_addr = ring base + wr_ptr, mem_wdata = push_data; push_done pulses at t+1; wr_ptr and count update at t+1's edge. Back to IDLE at t+2.
- Pop latency: READ at t+1: mem_rd=1, mem_addr = ring base + rd_ptr. READ_WAIT for MEM_RD_LAT cycles; mem_rdata is captured at t+1+MEM_RD_LAT. POP_DONE at t+2+MEM_RD_LAT: pop_done pulses, pop_data holds the word, rd_ptr and count update. Back to IDLE next cycle.
- Requestor rule: drop req on the edge where done or err is seen. A req still high in a later IDLE is treated as a new request.
- Pointers: RING_LOG2 bits, wrap modulo 2^RING_LOG2. The address never leaves the ring's window. count has RING_LOG2+1 bits.
- full/empty/count are registered and reflect the update one cycle after it occurs.
- Grant pointer updates on every grant, including err grants.
- flush[i]: next edge sets pointers and count of ring i to 0.
  - Flush has priority over a same-cycle pointer update on that ring.
  - A flushed in-flight op still pulses its done; the pushed word is discarded, and a popped word is delivered but not counted.
- pop_data holds its last value outside POP_DONE.

Decomposition:
- Shared package: FSM state enum; function ring_base(i) = BASE_ADDR + (i << RING_LOG2); count and pointer width localparams.
- One sub-module: rr_arbiter (parameter N; inputs req vector and enable; outputs one-hot grant and index; internal last-grant register).

Test Plan (NUM_RINGS=4, RING_LOG2=6, BASE_ADDR=0, MEM_RD_LAT=1):
1. Push 16'h0002 on ring 1 -> mem_wr with mem_addr 16'h0040 at t+1; push_done[1] at t+1; count[1]=1 and empty[1]=0 at t+2.
2. Then pop ring 1 -> mem_rd at 16'h0040 at t+1; pop_done[1] with pop_data 16'h0002 at t+3; count[1]=0.
3. Push 64 words 16'hAB00..16'hAB3F into ring 0 -> full[0]=1. 65th push -> push_err[0], no mem_wr. Pop one, then push 16'hFFA1 -> written at 16'h0000 (wrap); count[0]=64.
4. Pushes held on rings 0, 2, 3 simultaneously from reset -> grants in order 0, 2, 3. Ring 0 re-request plus ring 2 after that -> ring 0 served before ring 2.
5. Pop on empty ring 3 -> pop_err[3] one cycle later; mem_rd stays 0; count[3] stays 0.
6. rst during READ_WAIT -> no pop_done; all counts 0; empty=4'hF; next push on ring 2 writes 16'h0080. Flush[2] with 5 words queued -> count[2]=0 next cycle; following push writes 16'h0080.
